// File: rtl/fifo_status_monitor.sv
// Registered occupancy, watermark, edge-event and sticky error status
// for the cell-based FIFO, derived from the per-cell empty flags.
module fifo_status_monitor #(
  parameter int N_CELLS   = 16,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = 14,
  parameter int LVL_W     = $clog2(N_CELLS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CELLS-1:0] e_i,
  input  logic               wr_req,
  input  logic               rd_req,
  input  logic               clr_err,
  output logic [LVL_W-1:0]   level,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic               went_empty,
  output logic               went_full,
  output logic               overflow,
  output logic               underflow
);

  if (N_CELLS < 2 || N_CELLS > 256) begin : g_bad_cells
    $fatal(1, "fifo_status_monitor: N_CELLS out of range 2..256");
  end

  if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH
      || AF_THRESH > N_CELLS) begin : g_bad_thresh
    $fatal(1, "fifo_status_monitor: need 0 <= AE < AF <= N_CELLS");
  end

  if (LVL_W != $clog2(N_CELLS + 1)) begin : g_bad_lvl_w
    $fatal(1, "fifo_status_monitor: LVL_W must not be overridden");
  end

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(N_CELLS);
  localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);

  // Accumulator is LVL_W wide so a completely full array never wraps.
  function automatic logic [LVL_W-1:0] popcnt(
    input logic [N_CELLS-1:0] v
  );
    logic [LVL_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      c = c + LVL_W'(v[i]);
    end
    return c;
  endfunction

  logic [LVL_W-1:0] occ;
  logic             occ_empty;
  logic             occ_full;
  logic             ov_set;
  logic             un_set;

  always_comb begin
    occ       = popcnt(~e_i);
    occ_empty = (occ == '0);
    occ_full  = (occ == LVL_FULL);
  end

  // Errors judge against the registered flags the requesters saw.
  always_comb begin
    ov_set = wr_req & full & ~rd_req;
    un_set = rd_req & empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      went_empty   <= 1'b0;
      went_full    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= occ;
      empty        <= occ_empty;
      full         <= occ_full;
      almost_empty <= (occ <= LVL_AE);
      almost_full  <= (occ >= LVL_AF);
      went_empty   <= occ_empty & ~empty;
      went_full    <= occ_full & ~full;
      overflow     <= ov_set | (overflow & ~clr_err);
      underflow    <= un_set | (underflow & ~clr_err);
    end
  end

endmodule
